ofb_stream_core: RTL and testbench

Clocked, handshaked AES-128 OFB engine that replaces the purely combinational per-block OFB path with a streaming block. It runs at a parametrised segment width and keeps the feedback register internally, so the bench or host no longer carries the chain value between blocks. The same datapath performs encryption and decryption, since OFB is an XOR with a self-generated keystream. It sits between a segment source (file reader / DMA) and a segment sink. Messages can be chained across `cfg_load` via the continuation flag.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes128_enc_comb.sv | 25 ++
 rtl/ofb_stream_core.sv | 94 +++++++++
 tb/tb_ofb_stream_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block constants, FSM states and round primitives
// used by the OFB streaming engine.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_NR    = 10;

  typedef enum logic [1:0] {IDLE, GEN, RUN} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int unsigned round);
    case (round)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte k of the block is column k/4, row k%4 (column-major, MSB first).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Segment idx of blk (MSB first), returned in the low seg_w bits.
  function automatic logic [127:0] seg_slice(input logic [127:0] blk, input int unsigned idx,
                                             input int unsigned seg_w);
    return blk >> (AES_BLK_W - (idx + 1) * seg_w);
  endfunction

endpackage

// File: rtl/aes128_enc_comb.sv
// Fully unrolled combinational AES-128 encryption with on-the-fly key schedule.
module aes128_enc_comb
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] key,
  input  logic [AES_BLK_W-1:0] blk_in,
  output logic [AES_BLK_W-1:0] blk_out
);

  logic [AES_BLK_W-1:0] st;
  logic [AES_BLK_W-1:0] rk;

  always_comb begin
    rk = key;
    st = blk_in ^ key;
    for (int unsigned r = 1; r <= AES_NR; r++) begin
      rk = next_round_key(rk, rcon(r));
      st = shift_rows(sub_bytes(st));
      if (r != AES_NR) st = mix_columns(st);
      st = st ^ rk;
    end
    blk_out = st;
  end

endmodule

// File: rtl/ofb_stream_core.sv
// Streaming AES-128 OFB engine: keystream register, segment counter and
// registered output stage around a single combinational AES instance.
module ofb_stream_core
  import aes_pkg::*;
#(
  parameter int unsigned SEG_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_load,
  input  logic                 cfg_cont,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [SEG_W-1:0]     s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [SEG_W-1:0]     m_data,
  output logic                 m_last,
  output logic [AES_BLK_W-1:0] chain_out
);

  localparam int unsigned N_SEG = AES_BLK_W / SEG_W;
  localparam int unsigned CNT_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

  state_t               state_q, state_d;
  logic [AES_BLK_W-1:0] fb_q, key_q, aes_out;
  logic [CNT_W-1:0]     seg_cnt;
  logic                 seg_last;
  logic                 xfer;

  aes128_enc_comb u_aes (
    .key    (key_q),
    .blk_in (fb_q),
    .blk_out(aes_out)
  );

  assign busy      = (state_q != IDLE);
  assign s_ready   = (state_q == RUN) && (!m_valid || m_ready);
  assign xfer      = s_valid && s_ready;
  assign seg_last  = (seg_cnt == CNT_W'(N_SEG - 1));
  assign chain_out = fb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cfg_load) state_d = GEN;
      GEN:  state_d = RUN;
      RUN: begin
        if (xfer) begin
          if (s_last)        state_d = IDLE;
          else if (seg_last) state_d = GEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q    <= '0;
      key_q   <= '0;
      seg_cnt <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (state_q == IDLE && cfg_load) begin
        key_q   <= cfg_key;
        seg_cnt <= '0;
        if (!cfg_cont) fb_q <= cfg_iv;
      end
      if (state_q == GEN) fb_q <= aes_out;
      // A fill takes priority over a drain so back-to-back segments keep m_valid high.
      if (xfer) begin
        m_data  <= s_data ^ SEG_W'(seg_slice(fb_q, 32'(seg_cnt), SEG_W));
        m_last  <= s_last;
        m_valid <= 1'b1;
        seg_cnt <= seg_last ? '0 : seg_cnt + 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofb_stream_core.sv
// Directed bench for ofb_stream_core: a 128-bit and an 8-bit instance checked
// against the AES-128 OFB reference vectors.
module tb_ofb_stream_core;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] C2  = 128'h7789508d16918f03f53c52dac54ed825;
  localparam logic [127:0] O2  = 128'hd9a4dada0892239f6b8b3d7680e15674;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         a_rst_n, a_cfg_load, a_cfg_cont, a_busy, a_s_valid, a_s_ready, a_s_last;
  logic         a_m_valid, a_m_ready, a_m_last;
  logic [127:0] a_cfg_key, a_cfg_iv, a_s_data, a_m_data, a_chain_out;

  logic         b_rst_n, b_cfg_load, b_cfg_cont, b_busy, b_s_valid, b_s_ready, b_s_last;
  logic         b_m_valid, b_m_ready, b_m_last;
  logic [127:0] b_cfg_key, b_cfg_iv, b_chain_out;
  logic [7:0]   b_s_data, b_m_data;

  logic [7:0] rx  [0:31];
  int         tin [0:31];

  ofb_stream_core #(.SEG_W(128)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .cfg_load(a_cfg_load), .cfg_cont(a_cfg_cont),
    .cfg_key(a_cfg_key), .cfg_iv(a_cfg_iv), .busy(a_busy),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
    .chain_out(a_chain_out)
  );

  ofb_stream_core #(.SEG_W(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .cfg_load(b_cfg_load), .cfg_cont(b_cfg_cont),
    .cfg_key(b_cfg_key), .cfg_iv(b_cfg_iv), .busy(b_busy),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .chain_out(b_chain_out)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_a(input logic [127:0] iv, input logic cont);
    @(negedge clk);
    a_cfg_key = KEY; a_cfg_iv = iv; a_cfg_cont = cont; a_cfg_load = 1'b1;
    @(negedge clk);
    a_cfg_load = 1'b0;
  endtask

  task automatic xfer_a(input string tag, input logic [127:0] din, input logic last,
                        input logic [127:0] exp);
    int n = 0;
    a_s_data = din; a_s_last = last; a_s_valid = 1'b1; a_m_ready = 1'b1;
    while (!a_s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_rdy"}, a_s_ready, 1'b1);
    @(negedge clk);
    a_s_valid = 1'b0; a_s_last = 1'b0;
    chk1({tag, "_mvalid"}, a_m_valid, 1'b1);
    chk128(tag, a_m_data, exp);
    chk1({tag, "_mlast"}, a_m_last, last);
  endtask

  task automatic cfg_b(input logic [127:0] iv, input logic cont);
    @(negedge clk);
    b_cfg_key = KEY; b_cfg_iv = iv; b_cfg_cont = cont; b_cfg_load = 1'b1;
    @(negedge clk);
    b_cfg_load = 1'b0;
  endtask

  // Streams n bytes of P1||P2 into the 8-bit instance and checks each output
  // byte against C1||C2; bp enables random stalls and a load attempt while busy.
  task automatic run_b(input string tag, input int n, input logic last_end, input logic bp);
    int idx = 0;
    int rxn = 0;
    logic [255:0] msg_sh, exp_sh;
    for (int cyc = 0; cyc < 400 && rxn < n; cyc++) begin
      @(negedge clk);
      b_m_ready  = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
      b_cfg_load = bp && (cyc == 10);
      b_cfg_cont = 1'b0;
      b_cfg_iv   = ~IV;
      msg_sh     = {P1, P2} << (8 * idx);
      b_s_valid  = (idx < n);
      b_s_data   = msg_sh[255:248];
      b_s_last   = last_end && (idx == n - 1);
      #1;
      if (b_m_valid && !b_m_ready) chk1({tag, "_bp_sready"}, b_s_ready, 1'b0);
      if (b_m_valid && b_m_ready) begin
        exp_sh = {C1, C2} << (8 * rxn);
        chk8(tag, b_m_data, exp_sh[255:248]);
        chk1({tag, "_mlast"}, b_m_last, last_end && (rxn == n - 1));
        rx[rxn] = b_m_data;
        rxn++;
      end
      if (b_s_valid && b_s_ready) begin
        tin[idx] = cyc;
        idx++;
      end
    end
    @(negedge clk);
    b_s_valid = 1'b0; b_s_last = 1'b0; b_cfg_load = 1'b0;
    chk128({tag, "_count"}, 128'(rxn), 128'(n));
  endtask

  initial begin
    a_rst_n = 1'b0; a_cfg_load = 1'b0; a_cfg_cont = 1'b0; a_cfg_key = '0; a_cfg_iv = '0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b1;
    b_rst_n = 1'b0; b_cfg_load = 1'b0; b_cfg_cont = 1'b0; b_cfg_key = '0; b_cfg_iv = '0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_sready", a_s_ready, 1'b0);
    chk1("rst_mvalid", a_m_valid, 1'b0);
    chk128("rst_chain", a_chain_out, '0);
    chk128("rst_mdata", a_m_data, '0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Encrypt two blocks at SEG_W=128
    cfg_a(IV, 1'b0);
    chk1("gen_busy", a_busy, 1'b1);
    chk1("gen_sready", a_s_ready, 1'b0);
    xfer_a("enc_p1", P1, 1'b0, C1);
    xfer_a("enc_p2", P2, 1'b1, C2);
    chk1("enc_idle", a_busy, 1'b0);
    chk128("enc_chain", a_chain_out, O2);

    // Decrypt
    cfg_a(IV, 1'b0);
    xfer_a("dec_c1", C1, 1'b0, P1);
    xfer_a("dec_c2", C2, 1'b1, P2);

    // Continuation across a reload; the IV supplied on the resume must be ignored
    cfg_a(IV, 1'b0);
    xfer_a("cont_p1", P1, 1'b1, C1);
    chk128("cont_chain1", a_chain_out, P1 ^ C1);
    cfg_a(~IV, 1'b1);
    xfer_a("cont_p2", P2, 1'b1, C2);
    chk128("cont_chain2", a_chain_out, O2);

    // Bytewise at SEG_W=8
    chk1("b_rst_busy", b_busy, 1'b0);
    cfg_b(IV, 1'b0);
    run_b("byte", 32, 1'b1, 1'b0);
    chk8("byte0", rx[0], 8'h3b);
    chk8("byte15", rx[15], 8'h4a);
    chk8("byte16", rx[16], 8'h77);
    chk128("gap_first", 128'(tin[1] - tin[0]), 128'(1));
    chk128("gap_block", 128'(tin[16] - tin[15]), 128'(2));
    chk128("byte_chain", b_chain_out, O2);
    chk1("byte_idle", b_busy, 1'b0);

    // Random back-pressure with an ignored load mid-message
    cfg_b(IV, 1'b0);
    run_b("bp", 32, 1'b1, 1'b1);
    chk128("bp_chain", b_chain_out, O2);
    chk1("bp_idle", b_busy, 1'b0);

    // Reset mid-message after byte 5
    cfg_b(IV, 1'b0);
    run_b("pre", 5, 1'b0, 1'b0);
    chk1("pre_busy", b_busy, 1'b1);
    #2 b_rst_n = 1'b0;
    @(negedge clk);
    chk1("mrst_busy", b_busy, 1'b0);
    chk1("mrst_sready", b_s_ready, 1'b0);
    chk1("mrst_mvalid", b_m_valid, 1'b0);
    chk1("mrst_mlast", b_m_last, 1'b0);
    chk8("mrst_mdata", b_m_data, 8'h00);
    chk128("mrst_chain", b_chain_out, '0);
    b_rst_n = 1'b1;
    cfg_b(IV, 1'b0);
    run_b("post", 1, 1'b1, 1'b0);
    chk8("post_byte0", rx[0], 8'h3b);
    chk1("post_idle", b_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
